// File: rtl/spi_frame_pkg.sv
// Shared types and helpers for the SPI frame receiver.
// Optional checksum build: SPI_FRAME_CRC_EN.
package spi_frame_pkg;

  localparam logic [7:0] CRC_SEED  = 8'hA5;
  localparam int         MAX_BYTES = 16;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } asm_state_t;

  // XOR of the low nbytes bytes of a right-aligned frame
  function automatic logic [7:0] frame_xor(
    input logic [8*MAX_BYTES-1:0] frame,
    input int                     nbytes
  );
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < nbytes) acc = acc ^ frame[8*i +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/spi_frame_fifo.sv
// First-word-fall-through frame FIFO built from a register array.
// A pop frees a full slot for a push in the same cycle.
module spi_frame_fifo
  import spi_frame_pkg::*;
#(
  parameter int W     = 24,
  parameter int DEPTH = 2,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          w_do_push;
  logic          w_do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (r_level == LW'(DEPTH));
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign dout      = r_mem[r_rptr];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= din;
        r_wptr        <= nxt(r_wptr);
      end
      if (w_do_pop) r_rptr <= nxt(r_rptr);
      r_level <= r_level + LW'(w_do_push) - LW'(w_do_pop);
    end
  end

endmodule

// File: rtl/spi_frame_receiver.sv
// Assembles SPI bytes into frames and queues them in a frame FIFO.
// Define SPI_FRAME_CRC_EN to check a trailing XOR checksum byte.
module spi_frame_receiver
  import spi_frame_pkg::*;
#(
  parameter int FRAME_BYTES = 3,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 spi_data,
  input  logic                       spi_data_valid,
  input  logic                       spi_cs_n,
  output logic [8*FRAME_BYTES-1:0]   frame_data,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic                       short_frame,
  output logic                       overflow,
  output logic                       crc_err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int FW = 8 * FRAME_BYTES;
  localparam int CW = $clog2(FRAME_BYTES + 1);
  localparam int XW = 8 * MAX_BYTES;

  logic          r_cs_meta;
  logic          r_cs_sync;
  logic          r_cs_prev;
  asm_state_t    r_state;
  logic [CW-1:0] r_count;
  logic [FW-1:0] r_buf;
  logic          r_short;
  logic          r_ovf;

  logic          w_cs_rise;
  logic          w_accept;
  logic          w_complete;
  logic          w_abort;
  logic          w_crc_ok;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [FW-1:0] w_asm_frame;

  assign w_cs_rise  = r_cs_sync & ~r_cs_prev;
  // A strobe landing with the CS rise still counts
  assign w_accept   = spi_data_valid & (~r_cs_sync | w_cs_rise);
  assign w_complete = w_accept & (r_count == CW'(FRAME_BYTES - 1));
  assign w_abort    = w_cs_rise & ~w_complete
                    & ((r_state == ST_COLLECT) | w_accept);
  assign w_push     = w_complete & w_crc_ok;
  assign w_pop      = frame_valid & frame_ready;

  always_comb begin
    w_asm_frame = r_buf;
    for (int i = 0; i < FRAME_BYTES; i++) begin
      if (w_accept && (r_count == CW'(i)))
        w_asm_frame[FW-1-8*i -: 8] = spi_data;
    end
  end

`ifdef SPI_FRAME_CRC_EN
  logic r_crc_err;
  assign w_crc_ok = (frame_xor(XW'(w_asm_frame), FRAME_BYTES) == CRC_SEED);
  assign crc_err  = r_crc_err;

  always_ff @(posedge clk) begin
    if (reset) r_crc_err <= 1'b0;
    else       r_crc_err <= w_complete & ~w_crc_ok;
  end
`else
  assign w_crc_ok = 1'b1;
  assign crc_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cs_meta <= 1'b1;
      r_cs_sync <= 1'b1;
      r_cs_prev <= 1'b1;
    end else begin
      r_cs_meta <= spi_cs_n;
      r_cs_sync <= r_cs_meta;
      r_cs_prev <= r_cs_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_buf   <= '0;
    end else if (w_complete || w_abort) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else if (w_accept) begin
      r_state <= ST_COLLECT;
      r_count <= r_count + 1'b1;
      r_buf   <= w_asm_frame;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_short <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_short <= w_abort;
      r_ovf   <= w_push & w_full & ~w_pop;
    end
  end

  assign short_frame = r_short;
  assign overflow    = r_ovf;
  assign frame_valid = ~w_empty;

  spi_frame_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .din   (w_asm_frame),
    .pop   (w_pop),
    .dout  (frame_data),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed bench for spi_frame_receiver (FRAME_BYTES=3, FIFO_DEPTH=2).
// Expectations adapt when SPI_FRAME_CRC_EN is defined.
module tb_spi_frame_receiver;

  localparam int FB = 3;
  localparam int FD = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    spi_data = '0;
  logic          spi_data_valid = 1'b0;
  logic          spi_cs_n = 1'b1;
  logic [8*FB-1:0] frame_data;
  logic          frame_valid;
  logic          frame_ready = 1'b0;
  logic          short_frame;
  logic          overflow;
  logic          crc_err;
  logic [$clog2(FD):0] fifo_level;

  int n_tests = 0;
  int n_fail  = 0;
  int n_short = 0;
  int n_ovf   = 0;
  int n_crc   = 0;

  spi_frame_receiver #(
    .FRAME_BYTES (FB),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .spi_data       (spi_data),
    .spi_data_valid (spi_data_valid),
    .spi_cs_n       (spi_cs_n),
    .frame_data     (frame_data),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .short_frame    (short_frame),
    .overflow       (overflow),
    .crc_err        (crc_err),
    .fifo_level     (fifo_level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (short_frame) n_short++;
    if (overflow)    n_ovf++;
    if (crc_err)     n_crc++;
  end

  function automatic logic [7:0] lb(input logic [7:0] a, b, c);
`ifdef SPI_FRAME_CRC_EN
    return a ^ b ^ 8'hA5;
`else
    return c;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    spi_data       = b;
    spi_data_valid = 1'b1;
    tick();
    spi_data_valid = 1'b0;
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    repeat (3) tick();
  endtask

  task automatic cs_high();
    spi_cs_n = 1'b1;
    repeat (5) tick();
  endtask

  task automatic pop();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    n_tests++;
    if (frame_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", frame_valid);
    end
    n_tests++;
    if (fifo_level !== '0) begin
      n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level);
    end
    n_tests++;
    if (frame_data !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", frame_data);
    end
    n_tests++;
    if ({short_frame, overflow, crc_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000",
               {short_frame, overflow, crc_err});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [23:0] exp;
    int s0;
    exp = {8'hC1, 8'hC2, lb(8'hC1, 8'hC2, 8'hC3)};
    s0 = n_short;
    cs_low();
    send(8'hC1);
    send(8'hC2);
    n_tests++;
    if (frame_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_early_valid: got %b want 0", frame_valid);
    end
    send(exp[7:0]);
    n_tests++;
    if (frame_valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_valid: got %b want 1", frame_valid);
    end
    n_tests++;
    if (frame_data !== exp) begin
      n_fail++; $display("FAIL basic_data: got %h want %h", frame_data, exp);
    end
    n_tests++;
    if (fifo_level !== 2'd1) begin
      n_fail++; $display("FAIL basic_level: got %0d want 1", fifo_level);
    end
    cs_high();
    n_tests++;
    if (n_short - s0 !== 0) begin
      n_fail++; $display("FAIL basic_short: got %0d want 0", n_short - s0);
    end
    pop();
    n_tests++;
    if (frame_valid !== 1'b0 || fifo_level !== '0) begin
      n_fail++;
      $display("FAIL basic_pop: got valid=%b lvl=%0d want 0/0",
               frame_valid, fifo_level);
    end
  endtask

  task automatic test_short();
    logic [23:0] exp;
    int s0;
    exp = {8'h11, 8'h22, lb(8'h11, 8'h22, 8'h33)};
    s0 = n_short;
    cs_low();
    send(8'hC1);
    cs_high();
    n_tests++;
    if (n_short - s0 !== 1) begin
      n_fail++; $display("FAIL short_pulse: got %0d want 1", n_short - s0);
    end
    n_tests++;
    if (frame_valid !== 1'b0) begin
      n_fail++; $display("FAIL short_empty: got %b want 0", frame_valid);
    end
    cs_low();
    send(8'h11);
    send(8'h22);
    send(exp[7:0]);
    n_tests++;
    if (frame_data !== exp || frame_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL short_next: got %h v=%b want %h v=1",
               frame_data, frame_valid, exp);
    end
    cs_high();
    pop();
  endtask

  task automatic test_overflow();
    logic [23:0] e1, e2;
    int o0;
    e1 = {8'h01, 8'h02, lb(8'h01, 8'h02, 8'h03)};
    e2 = {8'h04, 8'h05, lb(8'h04, 8'h05, 8'h06)};
    o0 = n_ovf;
    cs_low();
    send(8'h01); send(8'h02); send(e1[7:0]);
    send(8'h04); send(8'h05); send(e2[7:0]);
    n_tests++;
    if (n_ovf - o0 !== 0) begin
      n_fail++; $display("FAIL ovf_early: got %0d want 0", n_ovf - o0);
    end
    send(8'h07); send(8'h08); send(lb(8'h07, 8'h08, 8'h09));
    tick();
    n_tests++;
    if (fifo_level !== 2'd2) begin
      n_fail++; $display("FAIL ovf_level: got %0d want 2", fifo_level);
    end
    n_tests++;
    if (n_ovf - o0 !== 1) begin
      n_fail++; $display("FAIL ovf_pulse: got %0d want 1", n_ovf - o0);
    end
    cs_high();
    n_tests++;
    if (frame_data !== e1) begin
      n_fail++; $display("FAIL ovf_drain1: got %h want %h", frame_data, e1);
    end
    pop();
    n_tests++;
    if (frame_data !== e2) begin
      n_fail++; $display("FAIL ovf_drain2: got %h want %h", frame_data, e2);
    end
    pop();
    n_tests++;
    if (frame_valid !== 1'b0) begin
      n_fail++; $display("FAIL ovf_empty: got %b want 0", frame_valid);
    end
  endtask

  task automatic test_push_pop_full();
    logic [23:0] ea, eb, ec;
    int o0;
    ea = {8'h0A, 8'h0B, lb(8'h0A, 8'h0B, 8'h0C)};
    eb = {8'h1A, 8'h1B, lb(8'h1A, 8'h1B, 8'h1C)};
    ec = {8'h2A, 8'h2B, lb(8'h2A, 8'h2B, 8'h2C)};
    o0 = n_ovf;
    cs_low();
    send(8'h0A); send(8'h0B); send(ea[7:0]);
    send(8'h1A); send(8'h1B); send(eb[7:0]);
    send(8'h2A); send(8'h2B);
    frame_ready = 1'b1;
    send(ec[7:0]);
    frame_ready = 1'b0;
    tick();
    n_tests++;
    if (fifo_level !== 2'd2) begin
      n_fail++; $display("FAIL pp_level: got %0d want 2", fifo_level);
    end
    n_tests++;
    if (n_ovf - o0 !== 0) begin
      n_fail++; $display("FAIL pp_ovf: got %0d want 0", n_ovf - o0);
    end
    n_tests++;
    if (frame_data !== eb) begin
      n_fail++; $display("FAIL pp_head: got %h want %h", frame_data, eb);
    end
    pop();
    n_tests++;
    if (frame_data !== ec) begin
      n_fail++; $display("FAIL pp_tail: got %h want %h", frame_data, ec);
    end
    pop();
    cs_high();
  endtask

  task automatic test_cs_coincident();
    logic [23:0] exp, e2;
    int s0;
    exp = {8'h55, 8'h66, lb(8'h55, 8'h66, 8'h77)};
    e2  = {8'h31, 8'h32, lb(8'h31, 8'h32, 8'h33)};
    s0 = n_short;
    cs_low();
    send(8'h55);
    send(8'h66);
    spi_cs_n = 1'b1;
    tick();
    tick();
    send(exp[7:0]);
    n_tests++;
    if (frame_valid !== 1'b1 || frame_data !== exp) begin
      n_fail++;
      $display("FAIL coinc_frame: got %h v=%b want %h v=1",
               frame_data, frame_valid, exp);
    end
    repeat (3) tick();
    n_tests++;
    if (n_short - s0 !== 0) begin
      n_fail++; $display("FAIL coinc_short: got %0d want 0", n_short - s0);
    end
    pop();
    send(8'h99);
    tick();
    n_tests++;
    if (fifo_level !== '0) begin
      n_fail++; $display("FAIL cs_high_ignore: got %0d want 0", fifo_level);
    end
    cs_low();
    send(8'h31); send(8'h32); send(e2[7:0]);
    n_tests++;
    if (frame_data !== e2) begin
      n_fail++; $display("FAIL cs_high_clean: got %h want %h", frame_data, e2);
    end
    pop();
    cs_high();
  endtask

  task automatic test_reset_mid();
    logic [23:0] exp;
    int s0;
    exp = {8'h41, 8'h42, lb(8'h41, 8'h42, 8'h43)};
    s0 = n_short;
    cs_low();
    send(8'hE1); send(8'hE2); send(lb(8'hE1, 8'hE2, 8'hE3));
    send(8'hAA);
    reset = 1'b1;
    tick();
    n_tests++;
    if (frame_valid !== 1'b0 || fifo_level !== '0 || frame_data !== '0) begin
      n_fail++;
      $display("FAIL rstmid_out: got v=%b l=%0d d=%h want 0/0/0",
               frame_valid, fifo_level, frame_data);
    end
    n_tests++;
    if ({short_frame, overflow, crc_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid_flags: got %b want 000",
               {short_frame, overflow, crc_err});
    end
    reset = 1'b0;
    repeat (3) tick();
    send(8'h41); send(8'h42); send(exp[7:0]);
    n_tests++;
    if (frame_data !== exp) begin
      n_fail++; $display("FAIL rstmid_next: got %h want %h", frame_data, exp);
    end
    cs_high();
    n_tests++;
    if (n_short - s0 !== 0) begin
      n_fail++; $display("FAIL rstmid_short: got %0d want 0", n_short - s0);
    end
    pop();
  endtask

`ifdef SPI_FRAME_CRC_EN
  task automatic test_crc();
    int c0;
    c0 = n_crc;
    cs_low();
    send(8'h12); send(8'h34); send(8'h83);
    n_tests++;
    if (frame_data !== 24'h123483 || frame_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL crc_good: got %h v=%b want 123483 v=1",
               frame_data, frame_valid);
    end
    pop();
    send(8'h12); send(8'h34); send(8'h00);
    tick();
    n_tests++;
    if (n_crc - c0 !== 1) begin
      n_fail++; $display("FAIL crc_pulse: got %0d want 1", n_crc - c0);
    end
    n_tests++;
    if (fifo_level !== '0) begin
      n_fail++; $display("FAIL crc_drop: got %0d want 0", fifo_level);
    end
    cs_high();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_overflow();
    test_push_pop_full();
    test_cs_coincident();
    test_reset_mid();
`ifdef SPI_FRAME_CRC_EN
    test_crc();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
